// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite motion block.
package sprite_pkg;

    // Vertical motion state, also exported on the debug state port.
    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } mstate_e;

    // Screen and sprite geometry.
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int SPRITE_W = 64;
    localparam int SPRITE_H = 64;

    // Clamp limits and reset positions at the width of the position registers.
    localparam logic [9:0] X_MAX    = 10'(SCREEN_W - SPRITE_W);   // 576
    localparam logic [8:0] GROUND_Y = 9'(SCREEN_H - SPRITE_H);    // 416
    localparam logic [9:0] START_X  = 10'd0;

    // Motion constants.
    localparam logic [9:0] STEP_X   = 10'd2;
    localparam logic [5:0] JUMP_V0  = 6'd12;
    localparam logic [5:0] GRAVITY  = 6'd1;
    localparam logic [5:0] MAX_FALL = 6'd12;

endpackage

// File: rtl/sprite_motion_btn_sync.sv
// Two-flop synchronizer for an asynchronous button with a rising-edge pulse.
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Synchronizer chain plus one delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign level_o = sync2_q;
    assign rise_o  = sync2_q & ~prev_q;

endmodule

// File: rtl/sprite_motion.sv
// Per-frame player sprite movement: horizontal walk with clamping and a
// ground/rise/fall jump under integer gravity. Position updates only on frame_tick.
module sprite_motion
    import sprite_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    output logic [9:0] posX,
    output logic [8:0] posY,
    output logic       airborne,
    output logic [1:0] state
);

    logic left_lvl, right_lvl, jump_lvl;
    logic jump_rise;
    logic left_rise_unused, right_rise_unused;

    btn_sync u_sync_left (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_left),
        .level_o (left_lvl),
        .rise_o  (left_rise_unused)
    );

    btn_sync u_sync_right (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_right),
        .level_o (right_lvl),
        .rise_o  (right_rise_unused)
    );

    btn_sync u_sync_jump (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_jump),
        .level_o (jump_lvl),
        .rise_o  (jump_rise)
    );

    logic       jump_req_q, jump_req_d;
    logic [9:0] posX_q, posX_d;
    logic [8:0] posY_q, posY_d;
    logic [5:0] vy_q, vy_d;
    mstate_e    state_q, state_d;
    logic       airborne_q, airborne_d;

    logic [10:0] x_sum;
    logic [6:0]  vy_sum;
    logic [5:0]  vy_fall;
    logic [9:0]  y_sum;

    // Sticky jump request: every tick clears it, but an edge landing on the
    // tick itself is kept for the following frame.
    always_comb begin
        jump_req_d = jump_req_q;
        if (frame_tick) begin
            jump_req_d = jump_rise;
        end else if (jump_rise) begin
            jump_req_d = 1'b1;
        end
    end

    // Horizontal step, widened to 11 bits so the clamp never sees a wrap.
    always_comb begin
        posX_d = posX_q;
        x_sum  = {1'b0, posX_q} + {1'b0, STEP_X};
        if (left_lvl && !right_lvl) begin
            posX_d = (posX_q < STEP_X) ? 10'd0 : (posX_q - STEP_X);
        end else if (right_lvl && !left_lvl) begin
            posX_d = (x_sum > {1'b0, X_MAX}) ? X_MAX : x_sum[9:0];
        end
    end

    // Vertical jump FSM next-state and position logic.
    always_comb begin
        state_d    = state_q;
        posY_d     = posY_q;
        vy_d       = vy_q;
        vy_sum     = {1'b0, vy_q} + {1'b0, GRAVITY};
        vy_fall    = (vy_sum > {1'b0, MAX_FALL}) ? MAX_FALL : vy_sum[5:0];
        y_sum      = {1'b0, posY_q} + {4'd0, vy_fall};
        case (state_q)
            GROUND: begin
                if (jump_req_q) begin
                    vy_d    = JUMP_V0;
                    state_d = RISE;
                end
            end
            RISE: begin
                if (posY_q < {3'd0, vy_q}) begin
                    posY_d  = 9'd0;
                    vy_d    = 6'd0;
                    state_d = FALL;
                end else begin
                    posY_d = posY_q - {3'd0, vy_q};
                    if (vy_q <= GRAVITY) begin
                        vy_d    = 6'd0;
                        state_d = FALL;
                    end else begin
                        vy_d = vy_q - GRAVITY;
                    end
                end
            end
            FALL: begin
                if (y_sum >= {1'b0, GROUND_Y}) begin
                    posY_d  = GROUND_Y;
                    vy_d    = 6'd0;
                    state_d = GROUND;
                end else begin
                    posY_d = y_sum[8:0];
                    vy_d   = vy_fall;
                end
            end
            default: begin
                posY_d  = GROUND_Y;
                vy_d    = 6'd0;
                state_d = GROUND;
            end
        endcase
        airborne_d = (state_d != GROUND);
    end

    // Motion registers: reset wins over the tick; otherwise update once per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            jump_req_q <= 1'b0;
            posX_q     <= START_X;
            posY_q     <= GROUND_Y;
            vy_q       <= 6'd0;
            state_q    <= GROUND;
            airborne_q <= 1'b0;
        end else begin
            jump_req_q <= jump_req_d;
            if (frame_tick) begin
                posX_q     <= posX_d;
                posY_q     <= posY_d;
                vy_q       <= vy_d;
                state_q    <= state_d;
                airborne_q <= airborne_d;
            end
        end
    end

    assign posX     = posX_q;
    assign posY     = posY_q;
    assign airborne = airborne_q;
    assign state    = state_q;

endmodule

// File: tb/tb_sprite_motion.sv
// Directed, table-driven bench for sprite_motion.
module tb_sprite_motion;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic       btn_left;
    logic       btn_right;
    logic       btn_jump;
    logic [9:0] posX;
    logic [8:0] posY;
    logic       airborne;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       l;
        logic       r;
        logic       j;
        int         x;
        int         y;
        int         st;
        int         air;
    } vec_t;

    vec_t tab1 [26];
    vec_t tab2 [26];

    // Hand-computed top edge after each tick of a jump launched from the ground.
    int traj_y [26] = '{416, 404, 393, 383, 374, 366, 359, 353, 348, 344, 341, 339, 338,
                        339, 341, 344, 348, 353, 359, 366, 374, 383, 393, 404, 416, 416};

    sprite_motion dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_jump   (btn_jump),
        .posX       (posX),
        .posY       (posY),
        .airborne   (airborne),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Leave time for the synchronizers, then pulse frame_tick for one cycle.
    task automatic do_tick();
        repeat (4) @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic run_table(input string tag, input vec_t tab [26]);
        for (int i = 0; i < 26; i++) begin
            btn_left  = tab[i].l;
            btn_right = tab[i].r;
            btn_jump  = tab[i].j;
            do_tick();
            chk($sformatf("%s_x_t%0d", tag, i + 1), int'(posX), tab[i].x);
            chk($sformatf("%s_y_t%0d", tag, i + 1), int'(posY), tab[i].y);
            chk($sformatf("%s_st_t%0d", tag, i + 1), int'(state), tab[i].st);
            chk($sformatf("%s_air_t%0d", tag, i + 1), int'(airborne), tab[i].air);
            if (i == 0) chk($sformatf("%s_vy_t1", tag), int'(dut.vy_q), 12);
        end
    endtask

    initial begin
        int ex;
        // Build the jump tables: ticks 1-12 RISE, 13-24 FALL, 25-26 GROUND.
        for (int i = 0; i < 26; i++) begin
            int st;
            st = (i < 12) ? 1 : ((i < 24) ? 2 : 0);
            tab1[i] = '{l: 1'b0, r: 1'b0, j: (i == 0 || i >= 4),
                        x: 556, y: traj_y[i], st: st, air: (st != 0)};
            tab2[i] = '{l: 1'b1, r: 1'b1, j: (i == 0),
                        x: 556, y: traj_y[i], st: st, air: (st != 0)};
        end

        rst = 1'b1; frame_tick = 1'b0;
        btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_x", int'(posX), 0);
        chk("rst_y", int'(posY), 416);
        chk("rst_st", int'(state), 0);
        chk("rst_air", int'(airborne), 0);

        for (int k = 1; k <= 5; k++) begin
            do_tick();
            chk($sformatf("idle_x_t%0d", k), int'(posX), 0);
            chk($sformatf("idle_y_t%0d", k), int'(posY), 416);
            chk($sformatf("idle_st_t%0d", k), int'(state), 0);
            chk($sformatf("idle_air_t%0d", k), int'(airborne), 0);
        end

        btn_right = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            do_tick();
            ex = (2 * k > 576) ? 576 : 2 * k;
            chk($sformatf("right_x_t%0d", k), int'(posX), ex);
        end
        chk("right_y", int'(posY), 416);

        btn_right = 1'b0;
        btn_left  = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            do_tick();
            chk($sformatf("left_x_t%0d", k), int'(posX), 576 - 2 * k);
        end
        btn_left = 1'b0;

        // Single jump, with a second press at tick 5 that must be discarded.
        run_table("jump", tab1);
        chk("jump_req_after_land", int'(dut.jump_req_q), 0);

        btn_jump = 1'b0;
        repeat (6) @(negedge clk);
        chk("no_req_on_release", int'(dut.jump_req_q), 0);

        // Both directions held during a jump: no horizontal motion.
        run_table("both", tab2);
        btn_left = 1'b0; btn_right = 1'b0;

        // Fresh edge after landing launches again.
        btn_jump = 1'b1;
        do_tick();
        chk("relaunch_st", int'(state), 1);
        chk("relaunch_y", int'(posY), 416);
        do_tick();
        chk("relaunch_y2", int'(posY), 404);

        // Queue a request, then reset on a tick cycle mid-flight.
        btn_jump = 1'b0;
        repeat (4) @(negedge clk);
        btn_jump = 1'b1;
        repeat (5) @(negedge clk);
        chk("req_pending", int'(dut.jump_req_q), 1);
        rst = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        frame_tick = 1'b0;
        chk("midrst_x", int'(posX), 0);
        chk("midrst_y", int'(posY), 416);
        chk("midrst_st", int'(state), 0);
        chk("midrst_air", int'(airborne), 0);
        chk("midrst_req", int'(dut.jump_req_q), 0);
        btn_jump = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_motion.md
Name: sprite_motion

Overview:
- Upstream stage of the sprite colour lookup. Produces the sprite's top-left screen coordinate (posX, posY) consumed by the pixel-colour stage.
- Moves the player sprite once per video frame. Inputs are the left, right and jump buttons, with a simple ground/rise/fall jump model under integer gravity.
- All position updates occur only on the frame tick, so the coordinates are stable for the whole active frame.

Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- SPRITE_W, 64, sprite width; right clamp is SCREEN_W-SPRITE_W = 576
- SPRITE_H, 64, sprite height
- GROUND_Y, 416, posY when standing (SCREEN_H-SPRITE_H)
- START_X, 0, posX after reset
- STEP_X, 2, horizontal pixels moved per frame
- JUMP_V0, 12, initial upward speed (pixels/frame)
- GRAVITY, 1, speed change per frame
- MAX_FALL, 12, terminal fall speed

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- btn_left  in  1  asynchronous button, active-high
- btn_right  in  1  asynchronous button, active-high
- btn_jump  in  1  asynchronous button, active-high
- posX  out  10  sprite left edge, registered
- posY  out  9  sprite top edge, registered
- airborne  out  1  high when state is not GROUND
- state  out  2  debug: 0 GROUND, 1 RISE, 2 FALL

Behaviour:
- Reset, sampled on the clk edge while rst=1:
  - posX=START_X, posY=GROUND_Y, vy=0, state=GROUND, airborne=0.
  - jump_req=0; synchronizer flops cleared.
  - rst overrides frame_tick in the same cycle.
- Buttons:
  - Each button passes through a 2-flop synchronizer.
  - A rising edge of synced jump sets sticky jump_req.
  - jump_req clears on every frame_tick (consumed or discarded).
  - Jump edge coincident with frame_tick: the tick uses the old jump_req, then jump_req is set for the next frame.
- Update timing:
  - Registers change only on the clk edge where frame_tick=1.
  - Outputs are valid on the cycle after the tick.
  - No change between ticks.
- Horizontal, using synced levels at the tick:
  - left only: posX -= STEP_X, saturating at 0.
  - right only: posX += STEP_X, saturating at 576.
  - Both or neither: no change.
  - Compute in 11 bits before the clamp; no wrap-around.
- Vertical FSM, vy unsigned 6-bit:
  - GROUND: if jump_req, then vy=JUMP_V0, state=RISE, posY unchanged this tick. Otherwise hold.
  - RISE: posY -= vy, with underflow clamped to 0 (force vy=0, go to FALL). vy -= GRAVITY. If the new vy is 0, go to FALL.
  - FALL: vy_n = min(vy+GRAVITY, MAX_FALL). If posY+vy_n >= GROUND_Y, then posY=GROUND_Y, vy=0, state=GROUND. Otherwise posY += vy_n, vy=vy_n.
  - A jump request while in RISE/FALL is discarded; no double jump.
- Horizontal and vertical updates happen in the same tick independently.
- airborne and state are registered with the FSM.
- frame_tick asserted on consecutive cycles: each cycle is a separate update; legal but not expected.

Decomposition:
- Package sprite_pkg holds:
  - state enum: GROUND/RISE/FALL, 2-bit.
  - Screen and sprite constants (640, 480, 64).
  - Clamp limits (576, 416).
- One sub-module, btn_sync: 2-FF synchronizer plus rising-edge pulse output. Instantiated three times; the edge output is used only for jump.

Test Plan:
- Reset, then 5 ticks with no buttons -> posX=0, posY=416, state=GROUND, airborne=0 throughout.
- btn_right held for 300 ticks -> posX increments by 2 per tick, reaches 576 at tick 288, stays 576. Then btn_left held 10 ticks -> posX=556.
- Jump pulse then ticks:
  - Tick 1 -> state RISE, posY=416, vy=12.
  - Tick 2 -> posY=404.
  - Tick 13 -> posY=338, state FALL.
  - Tick 25 -> posY=416, state GROUND.
  - airborne is high for ticks 1-24.
- Jump pressed again during RISE (tick 5) -> ignored. Lands at tick 25; no re-launch at tick 26 unless a new edge arrives after landing.
- btn_left and btn_right both held while jumping -> posX unchanged; vertical trajectory identical to the single-jump scenario.
- rst asserted mid-jump on a frame_tick cycle -> next cycle posY=416, posX=0, state=GROUND, jump_req=0.
